// File: rtl/min_max_seq_ctrl.sv
// rtl/min_max_seq_ctrl.sv - frame min/max tracker with first-occurrence indices over a valid/ready sample stream
module min_max_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int COUNT = 8,
  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [IDX_W-1:0] max_idx,
  output logic [IDX_W-1:0] min_idx,
  output logic             eq_all
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPARE, S_DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             start_ok;
  logic             gt;
  logic             lt;
  logic [WIDTH-1:0] nxt_max;
  logic [WIDTH-1:0] nxt_min;

  // in_ready mirrors the state register, so a handshake is only possible in LOAD/COMPARE
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign gt       = in_data > max_val;
  assign lt       = in_data < min_val;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a start outside IDLE/DONE falls through untouched
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_LOAD;
      S_LOAD:    if (accept) next_state = (COUNT == 1) ? S_DONE : S_COMPARE;
      S_COMPARE: if (accept && (count == LAST)) next_state = S_DONE;
      S_DONE:    next_state = start ? S_LOAD : S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Running extremes including the sample being accepted, so eq_all can be registered with done
  always_comb begin
    nxt_max = max_val;
    nxt_min = min_val;
    if (accept) begin
      if (state == S_LOAD) begin
        nxt_max = in_data;
        nxt_min = in_data;
      end else begin
        if (gt) nxt_max = in_data;
        if (lt) nxt_min = in_data;
      end
    end
  end

  // Registered handshake/status flags derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      eq_all   <= 1'b0;
    end else begin
      in_ready <= (next_state == S_LOAD) || (next_state == S_COMPARE);
      busy     <= (next_state == S_LOAD) || (next_state == S_COMPARE);
      done     <= (next_state == S_DONE);
      if (next_state == S_DONE)
        eq_all <= (nxt_max == nxt_min);
      else if (start_ok)
        eq_all <= 1'b0;
    end
  end

  // Datapath: strict compares only, so indices keep the earliest occurrence on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      max_val <= '0;
      min_val <= '0;
      max_idx <= '0;
      min_idx <= '0;
    end else if (start_ok) begin
      count <= '0;
    end else if (accept) begin
      max_val <= nxt_max;
      min_val <= nxt_min;
      if (state == S_LOAD) begin
        count   <= CNT_W'(1);
        max_idx <= '0;
        min_idx <= '0;
      end else begin
        count <= count + CNT_W'(1);
        if (gt) max_idx <= count[IDX_W-1:0];
        if (lt) min_idx <= count[IDX_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_min_max_seq_ctrl.sv
// tb/tb_min_max_seq_ctrl.sv - randomized self-checking bench for min_max_seq_ctrl (COUNT=8 and COUNT=1 builds)
module tb_min_max_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, in_valid;
  logic [3:0] in_data;
  logic       in_ready, busy, done, eq_all;
  logic [3:0] max_val, min_val;
  logic [2:0] max_idx, min_idx;

  logic       start1, in_valid1;
  logic [3:0] in_data1;
  logic       in_ready1, busy1, done1, eq_all1;
  logic [3:0] max_val1, min_val1;
  logic [0:0] max_idx1, min_idx1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  min_max_seq_ctrl #(.WIDTH(4), .COUNT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .max_val(max_val), .min_val(min_val),
    .max_idx(max_idx), .min_idx(min_idx), .eq_all(eq_all)
  );

  min_max_seq_ctrl #(.WIDTH(4), .COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .busy(busy1), .done(done1), .max_val(max_val1), .min_val(min_val1),
    .max_idx(max_idx1), .min_idx(min_idx1), .eq_all(eq_all1)
  );

  // Called at a negedge; raises start immediately, feeds 8 samples, returns at the done negedge.
  task automatic do_frame(input int s[8], input int gap, input bit hold, input string name);
    int q[$];
    int qi[$];
    int emax, emin, eimax, eimin, k, cyc;
    bit v;
    for (int i = 0; i < 8; i++) q.push_back(s[i]);
    qi = q.max();  emax = qi[0];
    qi = q.min();  emin = qi[0];
    qi = q.find_first_index(x) with (x == emax); eimax = qi[0];
    qi = q.find_first_index(x) with (x == emin); eimin = qi[0];
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 100) begin
      n_checks++;
      if ({busy, in_ready, done, eq_all} !== 4'b1100) begin
        n_fail++;
        $display("FAIL %s in-frame flags cyc %0d: got busy/ready/done/eq=%b expected 1100", name, cyc, {busy, in_ready, done, eq_all});
      end
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? 4'(s[k]) : 4'($urandom);
      @(negedge clk);
      cyc++;
      if (v) k++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (k != 8) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d samples accepted, expected 8", name, k);
    end
    n_checks++;
    if ({done, busy, in_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s done flags: got done/busy/ready=%b expected 100", name, {done, busy, in_ready});
    end
    n_checks++;
    if (max_val !== 4'(emax) || max_idx !== 3'(eimax) || min_val !== 4'(emin) || min_idx !== 3'(eimin) || eq_all !== (emax == emin)) begin
      n_fail++;
      $display("FAIL %s results: got max=%0d@%0d min=%0d@%0d eq=%b, expected max=%0d@%0d min=%0d@%0d eq=%b",
               name, max_val, max_idx, min_val, min_idx, eq_all, emax, eimax, emin, eimin, emax == emin);
    end
    if (hold) begin
      repeat (3) @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || max_val !== 4'(emax) || max_idx !== 3'(eimax) ||
          min_val !== 4'(emin) || min_idx !== 3'(eimin) || eq_all !== (emax == emin)) begin
        n_fail++;
        $display("FAIL %s hold: got done=%b busy=%b max=%0d@%0d min=%0d@%0d eq=%b, expected done=0 busy=0 max=%0d@%0d min=%0d@%0d eq=%b",
                 name, done, busy, max_val, max_idx, min_val, min_idx, eq_all, emax, eimax, emin, eimin, emax == emin);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, busy, done, eq_all, max_val, min_val, max_idx, min_idx} !== '0 ||
        {in_ready1, busy1, done1, eq_all1, max_val1, min_val1, max_idx1, min_idx1} !== '0) begin
      n_fail++;
      $display("FAIL reset state: got %h / %h expected all zero",
               {in_ready, busy, done, eq_all, max_val, min_val, max_idx, min_idx},
               {in_ready1, busy1, done1, eq_all1, max_val1, min_val1, max_idx1, min_idx1});
    end
  endtask

  task automatic test_ramp();
    int s[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    do_frame(s, 0, 1'b1, "ramp");
  endtask

  task automatic test_equal();
    int s[8] = '{5, 5, 5, 5, 5, 5, 5, 5};
    @(negedge clk);
    do_frame(s, 0, 1'b1, "equal");
  endtask

  task automatic test_ties();
    int s[8] = '{3, 9, 9, 1, 1, 4, 9, 2};
    @(negedge clk);
    do_frame(s, 0, 1'b1, "ties");
  endtask

  task automatic test_gaps();
    int s[8] = '{15, 0, 7, 15, 3, 0, 12, 8};
    @(negedge clk);
    do_frame(s, 1, 1'b1, "gaps");
  endtask

  task automatic test_back_to_back();
    int a[8] = '{4, 2, 8, 8, 1, 6, 2, 0};
    int b[8] = '{9, 9, 9, 9, 9, 9, 9, 9};
    @(negedge clk);
    do_frame(a, 0, 1'b0, "b2b_first");
    do_frame(b, 0, 1'b1, "b2b_second");
  endtask

  task automatic test_random();
    int s[8];
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 8; i++) s[i] = (f == 5) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 15));
      @(negedge clk);
      do_frame(s, 2, 1'b1, "random");
    end
  endtask

  task automatic test_midframe_reset();
    int d[3] = '{2, 9, 4};
    int s[8];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(d[i]);
      start    = (i == 1);
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || max_val !== 4'd9 || max_idx !== 3'd1 || min_val !== 4'd2 || min_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL midframe start ignored: got busy=%b max=%0d@%0d min=%0d@%0d expected busy=1 max=9@1 min=2@0",
               busy, max_val, max_idx, min_val, min_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, busy, done, eq_all, max_val, min_val, max_idx, min_idx} !== '0) begin
      n_fail++;
      $display("FAIL async reset: got %h expected all zero", {in_ready, busy, done, eq_all, max_val, min_val, max_idx, min_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL post-reset idle: got ready/busy/done=%b expected 000", {in_ready, busy, done});
    end
    for (int i = 0; i < 8; i++) s[i] = int'($urandom_range(0, 15));
    do_frame(s, 2, 1'b1, "after_reset");
  endtask

  task automatic test_count1();
    logic [3:0] vals[2] = '{4'hA, 4'h3};
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n_checks++;
      if ({in_ready1, busy1, done1} !== 3'b110) begin
        n_fail++;
        $display("FAIL count1 load flags: got ready/busy/done=%b expected 110", {in_ready1, busy1, done1});
      end
      in_valid1 = 1'b1;
      in_data1  = vals[f];
      @(negedge clk);
      in_valid1 = 1'b0;
      n_checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || max_val1 !== vals[f] || min_val1 !== vals[f] ||
          max_idx1 !== 1'b0 || min_idx1 !== 1'b0 || eq_all1 !== 1'b1) begin
        n_fail++;
        $display("FAIL count1 result: got done=%b busy=%b max=%h@%0d min=%h@%0d eq=%b expected done=1 busy=0 max=%h@0 min=%h@0 eq=1",
                 done1, busy1, max_val1, max_idx1, min_val1, min_idx1, eq_all1, vals[f], vals[f]);
      end
      @(negedge clk);
      n_checks++;
      if (done1 !== 1'b0) begin
        n_fail++;
        $display("FAIL count1 done pulse width: got done=%b expected 0", done1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_equal();
    test_ties();
    test_gaps();
    test_back_to_back();
    test_random();
    test_midframe_reset();
    test_count1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
